// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO round-robin drain scheduler.
package fifo_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Bits needed to index n items; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req searching upward from last+1, wrapping.
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter  int NUM_Q = 4,
  localparam int IW    = clog2(NUM_Q)
) (
  input  logic [NUM_Q-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW-1:0] p;

  always_comb begin
    idx = '0;
    any = 1'b0;
    p   = '0;
    for (int k = 1; k <= NUM_Q; k++) begin
      p = IW'((int'(last) + k) % NUM_Q);
      if (!any && req[p]) begin
        any = 1'b1;
        idx = p;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin drain scheduler: grants one FIFO at a time for up to BURST words,
// muxing its head word onto the shared output and strobing its shift_out.
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter  int NUM_Q = 4,
  parameter  int WIDTH = 4,
  parameter  int BURST = 4,
  localparam int GW    = clog2(NUM_Q)
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [NUM_Q-1:0]       q_empty_n,
  input  logic [NUM_Q*WIDTH-1:0] q_data,
  input  logic [NUM_Q-1:0]       q_mask,
  output logic [NUM_Q-1:0]       q_shift_out,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [GW-1:0]          grant_id,
  output logic                   busy
);

  // state | meaning
  // IDLE  | no grant; pick next candidate after the last grant
  // XFER  | queue grant_q owns the output port for up to BURST words

  localparam int              BW        = (clog2(BURST) < 1) ? 1 : clog2(BURST);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST - 1);

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [BW-1:0]    beat_q,  beat_d;
  logic [GW-1:0]    pick_idx;
  logic             pick_any;
  logic             xfer;
  logic [WIDTH-1:0] q_word [NUM_Q];

  for (genvar i = 0; i < NUM_Q; i++) begin : g_word
    assign q_word[i] = q_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NUM_Q(NUM_Q)) u_pick (
    .req  (q_empty_n & q_mask),
    .last (grant_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Pointer resets to the top index so the first search starts at queue 0.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_Q - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    out_valid   = 1'b0;
    out_data    = '0;
    q_shift_out = '0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        out_valid            = q_empty_n[grant_q] & q_mask[grant_q];
        out_data             = q_word[grant_q];
        xfer                 = out_valid & out_ready;
        q_shift_out[grant_q] = xfer;
        if (!out_valid) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (beat_q == LAST_BEAT) state_d = IDLE;
          else                     beat_d  = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == XFER);

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Self-checking bench for fifo_rr_sched: queue-based FIFO bank and burst-ownership model,
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_fifo_rr_sched;

  localparam int NQ = 4;
  localparam int W  = 4;
  localparam int B  = 4;

  logic            clk;
  logic            res;
  logic [NQ-1:0]   q_empty_n;
  logic [NQ*W-1:0] q_data;
  logic [NQ-1:0]   q_mask;
  logic [NQ-1:0]   q_shift_out;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_rr_sched #(.NUM_Q(NQ), .WIDTH(W), .BURST(B)) dut (
    .clk         (clk),
    .res         (res),
    .q_empty_n   (q_empty_n),
    .q_data      (q_data),
    .q_mask      (q_mask),
    .q_shift_out (q_shift_out),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO contents and the scheduler's view: who owns the port and how many words taken.
  logic [W-1:0] fq [NQ][$];
  bit  m_busy  = 1'b0;
  int  m_grant = NQ - 1;
  int  m_beats = 0;
  int  cyc     = 0;
  int  pop_q[$];
  int  pop_d[$];
  int  pop_c[$];
  int  checks  = 0;
  int  errors  = 0;
  bit  chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: actual %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < NQ; i++) begin
      q_empty_n[i]     = (fq[i].size() != 0);
      q_data[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic push(input int q, input int v);
    fq[q].push_back(W'(v));
    drive_fifo();
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NQ; i++) fq[i].delete();
    drive_fifo();
  endtask

  // Advance one clock: apply the scheduling rules to the inputs seen at this edge.
  task automatic step();
    bit v;
    bit found;
    @(posedge clk);
    cyc++;
    if (res) begin
      m_busy  = 1'b0;
      m_grant = NQ - 1;
      m_beats = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= NQ; k++) begin
        int p;
        p = (m_grant + k) % NQ;
        if (!found && fq[p].size() != 0 && q_mask[p]) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_grant = p;
          m_beats = 0;
        end
      end
    end else begin
      v = (fq[m_grant].size() != 0) && q_mask[m_grant];
      if (!v) begin
        m_busy = 1'b0;
      end else if (out_ready) begin
        pop_q.push_back(m_grant);
        pop_d.push_back(int'(fq[m_grant].pop_front()));
        pop_c.push_back(cyc);
        m_beats++;
        if (m_beats == B) m_busy = 1'b0;
      end
    end
    #1;
    drive_fifo();
  endtask

  task automatic run_pops(input int n, input int budget);
    int target;
    target = pop_q.size() + n;
    while (pop_q.size() < target && budget > 0) begin
      step();
      budget--;
    end
    if (pop_q.size() < target) begin
      checks++;
      errors++;
      $display("FAIL run_pops_timeout cycle %0d: pops %0d required %0d", cyc, pop_q.size(), target);
    end
  endtask

  task automatic do_reset();
    res = 1'b1;
    clear_fifos();
    step();
    step();
    res = 1'b0;
  endtask

  always @(negedge clk) begin : cmp
    bit ev;
    int ed, es, eb, eg;
    if (chk_en) begin
      if (res) begin
        ev = 1'b0; ed = 0; es = 0; eb = 0; eg = NQ - 1;
      end else begin
        ev = m_busy && (fq[m_grant].size() != 0) && q_mask[m_grant];
        ed = (m_busy && fq[m_grant].size() != 0) ? int'(fq[m_grant][0]) : 0;
        es = (ev && out_ready) ? (1 << m_grant) : 0;
        eb = m_busy;
        eg = m_grant;
      end
      chk("out_valid",   int'(out_valid),   int'(ev));
      chk("out_data",    int'(out_data),    ed);
      chk("q_shift_out", int'(q_shift_out), es);
      chk("busy",        int'(busy),        eb);
      chk("grant_id",    int'(grant_id),    eg);
    end
  end

  initial begin
    int c0, s;
    int e1[6];
    res       = 1'b1;
    q_mask    = '1;
    out_ready = 1'b1;
    q_empty_n = '0;
    q_data    = '0;
    chk_en    = 1'b1;

    // Single queue, 6 words: 4-word burst, one bubble, 2 more words.
    do_reset();
    chk("t1_grant_after_reset", int'(grant_id), 3);
    for (int v = 1; v <= 6; v++) push(0, v);
    c0 = cyc;
    s  = pop_q.size();
    repeat (10) step();
    e1 = '{2, 3, 4, 5, 7, 8};
    chk("t1_pop_count", pop_q.size() - s, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t1_pop_cycle", pop_c[s+i] - c0, e1[i]);
      chk("t1_pop_data",  pop_d[s+i], i + 1);
    end
    chk("t1_busy_end",  int'(busy), 0);
    chk("t1_valid_end", int'(out_valid), 0);

    // All queues full: grant order 0,1,2,3,0,... with 4 words and one bubble each.
    do_reset();
    for (int q = 0; q < NQ; q++)
      for (int i = 0; i < 8; i++) push(q, int'($urandom_range(0, 15)));
    c0 = cyc;
    s  = pop_q.size();
    run_pops(32, 200);
    for (int i = 0; i < 32; i++) begin
      chk("t2_grant_order", pop_q[s+i], (i / 4) % NQ);
      chk("t2_pop_cycle",   pop_c[s+i] - c0, 2 + i + i / 4);
    end

    // Stall queue 2 for 10 cycles mid-burst.
    do_reset();
    for (int v = 9; v <= 14; v++) push(2, v);
    s = pop_q.size();
    run_pops(2, 20);
    out_ready = 1'b0;
    repeat (10) step();
    chk("t3_stall_pops", pop_q.size() - s, 2);
    out_ready = 1'b1;
    run_pops(4, 30);
    for (int i = 0; i < 6; i++) begin
      chk("t3_data_order", pop_d[s+i], 9 + i);
      chk("t3_queue",      pop_q[s+i], 2);
    end
    chk("t3_release_gap", pop_c[s+2] - pop_c[s+1], 11);
    chk("t3_bubble_gap",  pop_c[s+4] - pop_c[s+3], 2);

    // Mask queue 1 after 2 pops: valid drops at once, next grant skips to queue 3.
    do_reset();
    for (int v = 1; v <= 6; v++) push(1, v);
    for (int v = 13; v <= 15; v++) push(3, v);
    s = pop_q.size();
    run_pops(2, 20);
    q_mask[1] = 1'b0;
    #1;
    chk("t4_valid_drop", int'(out_valid), 0);
    chk("t4_no_pop",     int'(q_shift_out), 0);
    run_pops(3, 30);
    chk("t4_first_q",  pop_q[s],   1);
    chk("t4_second_q", pop_q[s+1], 1);
    for (int i = 2; i < 5; i++) begin
      chk("t4_next_q",   pop_q[s+i], 3);
      chk("t4_next_data", pop_d[s+i], 11 + i);
    end
    q_mask = '1;

    // Short queue 3 (2 words) ends the burst early, next grant wraps to queue 0.
    do_reset();
    push(3, 7);
    push(3, 8);
    s = pop_q.size();
    run_pops(1, 10);
    push(0, 1);
    push(0, 2);
    push(0, 3);
    run_pops(2, 20);
    chk("t5_q_a",   pop_q[s],   3);
    chk("t5_q_b",   pop_q[s+1], 3);
    chk("t5_q_c",   pop_q[s+2], 0);
    chk("t5_gap",   pop_c[s+2] - pop_c[s+1], 3);

    // Reset asserted mid-burst with handshake active.
    do_reset();
    for (int v = 1; v <= 6; v++) push(2, v);
    run_pops(1, 10);
    push(1, 5);
    push(1, 6);
    res = 1'b1;
    #1;
    chk("t6_shift_in_reset", int'(q_shift_out), 0);
    chk("t6_busy_in_reset",  int'(busy), 0);
    step();
    chk("t6_word_kept", fq[2].size(), 5);
    step();
    res = 1'b0;
    chk("t6_grant_id", int'(grant_id), 3);
    run_pops(1, 10);
    chk("t6_first_grant", pop_q[pop_q.size()-1], 1);

    // Randomized traffic, masks and back-pressure.
    do_reset();
    repeat (3000) begin
      int q;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NQ; i++) q_mask[i] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) begin
        q = int'($urandom_range(0, NQ - 1));
        if (fq[q].size() < 8) push(q, int'($urandom_range(0, 15)));
      end
      step();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rr_sched.md
# fifo_rr_sched

Round-robin drain scheduler for `NUM_Q` register-based FIFOs that share one downstream `WIDTH`-bit port. It watches each FIFO's `empty_n`, grants one queue at a time, and pulses that queue's `shift_out` for each accepted word. A grant lasts for at most `BURST` words before the grant passes to the next queue. The block sits between the FIFO bank and the single consumer and is the only driver of the FIFOs' `shift_out` lines.

## Interface
- `NUM_Q`, 4: number of FIFOs served; must be ≥2.
- `WIDTH`, 4: data width of each FIFO and of the output.
- `BURST`, 4: maximum words per grant; must be ≥1.

- `clk` input 1: single clock, rising edge.
- `res` input 1: asynchronous, active-high reset.
- `q_empty_n` input `NUM_Q`: per-FIFO not-empty flag. Bit i belongs to queue i.
- `q_data` input `NUM_Q*WIDTH`: per-FIFO head word. Queue i occupies bits `[i*WIDTH +: WIDTH]`.
- `q_mask` input `NUM_Q`: per-queue enable. 0 means the queue is skipped by arbitration.
- `q_shift_out` output `NUM_Q`: per-FIFO pop strobe, one-hot or zero.
- `out_data` output `WIDTH`: head word of the granted queue.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: the consumer accepts the word.
- `grant_id` output `clog2(NUM_Q)`: index of the current or last-granted queue.
- `busy` output 1: the scheduler is in XFER.

## Operation
- The FSM has two states: IDLE and XFER.
- Candidate set = `q_empty_n & q_mask`.
- **IDLE**
  - `out_valid` = 0.
  - If the candidate set is non-zero, select the first set bit searching from `grant+1`, wrapping modulo `NUM_Q`.
  - Register the selection into `grant`, clear `beat_cnt`, and go to XFER.
  - Otherwise stay in IDLE; `grant` is unchanged.
- **XFER**
  - `out_valid` = `q_empty_n[grant] & q_mask[grant]`.
  - `out_data` = `q_data[grant]`.
  - `q_shift_out[grant]` = `out_valid & out_ready`; all other bits are 0.
  - A transfer is `out_valid & out_ready`. Each transfer increments `beat_cnt`.
- **Leave XFER for IDLE when either:**
  - a transfer occurs with `beat_cnt == BURST-1`, or
  - `out_valid` is 0, meaning the granted queue is empty or masked.
- Outside XFER, `out_data` = 0 and `q_shift_out` = 0.
- `beat_cnt` width is `max(1, clog2(BURST))`. It is never compared past `BURST-1` and never wraps inside a grant.
- If `out_ready` is low, nothing pops and `beat_cnt` holds. A stall may last indefinitely; there is no timeout.
- Masking the granted queue mid-burst drops `out_valid` in the same cycle (combinational). The FSM returns to IDLE on the next edge and no pop occurs.
- A queue whose `empty_n` falls after its last pop: the FIFO flag is registered, so `out_valid` drops the cycle after the final pop. That cycle ends the burst.
- A single non-empty queue that exhausts `BURST` is re-granted after one IDLE cycle. The round-robin search wraps back to the same queue.

## Timing
- All registers (`state`, `grant`, `beat_cnt`) reset asynchronously on `res`.
- Reset values:
  - state = IDLE
  - `grant` = `grant_id` = `NUM_Q-1`, so the first pick after reset favours queue 0
  - `beat_cnt` = 0
- Output values during reset: `out_valid` = 0, `out_data` = 0, `q_shift_out` = 0, `busy` = 0.
- Latency:
  - Candidate set goes non-zero while in IDLE at cycle t → `busy` and `out_valid` high at t+1.
  - `out_data`, `out_valid` and `q_shift_out` are combinational from `grant`/`state` and the queue inputs. There are no extra pipeline stages.
- Each burst end costs exactly one IDLE bubble cycle.
- Peak throughput is `BURST/(BURST+1)` words per cycle.
- Reset asserted mid-burst:
  - All outputs go to their reset values immediately.
  - The word under handshake in that cycle is not popped.
  - The round-robin pointer restarts at `NUM_Q-1`.

## Structure
- Shared package/header `fifo_sched_pkg` holds:
  - state encodings: IDLE=1'b0, XFER=1'b1
  - a `clog2` function used for `grant` and `beat_cnt` widths
- Sub-module `rr_pick #(NUM_Q)`:
  - purely combinational rotating-priority picker
  - inputs: `req[NUM_Q]`, `last[clog2(NUM_Q)]`
  - outputs: `idx`, `any`
  - instantiated once in IDLE selection
- Top level holds the FSM, `beat_cnt`, the output mux and the `q_shift_out` decode.

## Test plan
- Reset, then `q_empty_n`=0001 with 6 words in queue 0 and `out_ready`=1 → queue 0 words 1–4 on cycles 1–4, one bubble, words 5–6, then `out_valid`=0 and `busy`=0.
- `q_empty_n`=1111, each queue holding 8 words, `BURST`=4 → grant order 0,1,2,3,0…; each grant pops exactly 4 words with one bubble between grants.
- Queue 2 granted and `out_ready` held low for 10 cycles → `q_shift_out`=0 and `beat_cnt` frozen; on release, the remaining beats complete with data order intact.
- Queue 1 granted with `q_mask[1]` cleared after 2 pops → `out_valid` drops the same cycle with no third pop; the next grant goes to the next enabled non-empty queue and queue 1 is skipped.
- Queue 3 holds 2 words and `BURST`=4 → 2 pops, then `out_valid`=0 the cycle after the second pop, and the next grant wraps to queue 0.
- `res` asserted during a burst with `out_ready`=1 → `q_shift_out`=0 in that cycle; after release, `grant_id`=3 and the first grant goes to the lowest non-empty queue.
